level_mem_arbiter: RTL and testbench

//  Shares one single-port level tile RAM between the display fetch path and the

---
 rtl/level_mem_arbiter.sv | 155 +++++++++++++++
 tb/tb_level_mem_arbiter.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/level_mem_arbiter.sv
// Shares the single-port level tile RAM between display fetches and collision queries.
// Display always wins the read slot; collision queries use a one-outstanding valid/ready handshake.
module level_mem_arbiter #(
   parameter int unsigned TILE_SHIFT = 5,
   parameter int unsigned COLS       = 20,
   parameter int unsigned ROWS       = 15,
   parameter int unsigned ADDR_W     = 9,
   parameter int unsigned DATA_W     = 3,
   parameter int unsigned RD_LAT     = 1,
   parameter int unsigned OOB_DISP   = 0,
   parameter int unsigned OOB_COL    = 1
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic              disp_req_i,
   input  logic [9:0]        disp_x_i,
   input  logic [9:0]        disp_y_i,
   output logic              disp_valid_o,
   output logic [DATA_W-1:0] disp_data_o,
   input  logic              col_req_valid_i,
   output logic              col_req_ready_o,
   input  logic [9:0]        col_x_i,
   input  logic [9:0]        col_y_i,
   output logic              col_rsp_valid_o,
   output logic [DATA_W-1:0] col_rsp_data_o,
   output logic              mem_en_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   input  logic [DATA_W-1:0] mem_rdata_i
);

   typedef enum logic [1:0] {CIdle, CPend, CWait} col_st_e;

   function automatic logic [ADDR_W-1:0] tile_addr(input logic [9:0] x, input logic [9:0] y);
      logic [9:0]  tx;
      logic [9:0]  ty;
      logic [19:0] a;
      tx = x >> TILE_SHIFT;
      ty = y >> TILE_SHIFT;
      a  = 20'(ty) * 20'(COLS) + 20'(tx);
      return a[ADDR_W-1:0];
   endfunction

   function automatic logic tile_oob(input logic [9:0] x, input logic [9:0] y);
      logic [9:0] tx;
      logic [9:0] ty;
      tx = x >> TILE_SHIFT;
      ty = y >> TILE_SHIFT;
      return (32'(tx) >= COLS) || (32'(ty) >= ROWS);
   endfunction

   col_st_e             state_q;
   logic                disp_valid_q;
   logic [DATA_W-1:0]   disp_data_q;
   logic                col_req_ready_q;
   logic                col_rsp_valid_q;
   logic [DATA_W-1:0]   col_rsp_data_q;
   logic                mem_en_q;
   logic [ADDR_W-1:0]   mem_addr_q;
   logic [ADDR_W-1:0]   col_addr_q;
   logic                col_oob_q;

   // Per-stage tags, stage RD_LAT lines up with mem_rdata_i. Display and collision
   // each get their own slot so an OOB query can retire alongside a display read.
   logic [RD_LAT:0]     dv_q;
   logic [RD_LAT:0]     doob_q;
   logic [RD_LAT:0]     cv_q;
   logic [RD_LAT:0]     coob_q;

   logic                disp_oob;
   logic [ADDR_W-1:0]   disp_addr;
   logic                disp_issue;
   logic                col_fire;
   logic                col_mem;

   always_comb begin
      disp_oob   = tile_oob(disp_x_i, disp_y_i);
      disp_addr  = tile_addr(disp_x_i, disp_y_i);
      disp_issue = disp_req_i && !disp_oob;
      // OOB queries need no RAM slot, so they never yield to the display
      col_fire   = (state_q == CPend) && (col_oob_q || !disp_req_i);
      col_mem    = col_fire && !col_oob_q;
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q         <= CIdle;
         disp_valid_q    <= 1'b0;
         disp_data_q     <= '0;
         col_req_ready_q <= 1'b1;
         col_rsp_valid_q <= 1'b0;
         col_rsp_data_q  <= '0;
         mem_en_q        <= 1'b0;
         mem_addr_q      <= '0;
         col_addr_q      <= '0;
         col_oob_q       <= 1'b0;
         dv_q            <= '0;
         doob_q          <= '0;
         cv_q            <= '0;
         coob_q          <= '0;
      end else begin
         mem_en_q <= disp_issue || col_mem;
         if (disp_issue) begin
            mem_addr_q <= disp_addr;
         end else if (col_mem) begin
            mem_addr_q <= col_addr_q;
         end

         dv_q   <= {dv_q[RD_LAT-1:0], disp_req_i};
         doob_q <= {doob_q[RD_LAT-1:0], disp_oob};
         cv_q   <= {cv_q[RD_LAT-1:0], col_fire};
         coob_q <= {coob_q[RD_LAT-1:0], col_oob_q};

         disp_valid_q <= dv_q[RD_LAT];
         if (dv_q[RD_LAT]) begin
            disp_data_q <= doob_q[RD_LAT] ? DATA_W'(OOB_DISP) : mem_rdata_i;
         end

         col_rsp_valid_q <= 1'b0;
         unique case (state_q)
            CIdle: begin
               if (col_req_valid_i && col_req_ready_q) begin
                  col_addr_q      <= tile_addr(col_x_i, col_y_i);
                  col_oob_q       <= tile_oob(col_x_i, col_y_i);
                  col_req_ready_q <= 1'b0;
                  state_q         <= CPend;
               end else begin
                  col_req_ready_q <= 1'b1;
               end
            end
            CPend: begin
               if (col_fire) begin
                  state_q <= CWait;
               end
            end
            CWait: begin
               if (cv_q[RD_LAT]) begin
                  col_rsp_valid_q <= 1'b1;
                  col_rsp_data_q  <= coob_q[RD_LAT] ? DATA_W'(OOB_COL) : mem_rdata_i;
                  state_q         <= CIdle;
               end
            end
            default: state_q <= CIdle;
         endcase
      end
   end

   assign disp_valid_o    = disp_valid_q;
   assign disp_data_o     = disp_data_q;
   assign col_req_ready_o = col_req_ready_q;
   assign col_rsp_valid_o = col_rsp_valid_q;
   assign col_rsp_data_o  = col_rsp_data_q;
   assign mem_en_o        = mem_en_q;
   assign mem_addr_o      = mem_addr_q;

endmodule

// File: tb/tb_level_mem_arbiter.sv
// Directed and random stimulus for level_mem_arbiter, checked every cycle against a
// transaction-level model (response queues with due cycles) and a behavioural RAM.
module tb_level_mem_arbiter;

   localparam int RD_LAT   = 1;
   localparam int OOB_DISP = 0;
   localparam int OOB_COL  = 1;

   logic       clk = 1'b0;
   logic       reset;
   logic       disp_req;
   logic [9:0] disp_x, disp_y;
   logic       disp_valid;
   logic [2:0] disp_data;
   logic       col_req_valid, col_req_ready;
   logic [9:0] col_x, col_y;
   logic       col_rsp_valid;
   logic [2:0] col_rsp_data;
   logic       mem_en;
   logic [8:0] mem_addr;
   logic [2:0] mem_rdata;

   always #5 clk = ~clk;

   level_mem_arbiter dut (
      .clk_i           (clk),
      .reset_i         (reset),
      .disp_req_i      (disp_req),
      .disp_x_i        (disp_x),
      .disp_y_i        (disp_y),
      .disp_valid_o    (disp_valid),
      .disp_data_o     (disp_data),
      .col_req_valid_i (col_req_valid),
      .col_req_ready_o (col_req_ready),
      .col_x_i         (col_x),
      .col_y_i         (col_y),
      .col_rsp_valid_o (col_rsp_valid),
      .col_rsp_data_o  (col_rsp_data),
      .mem_en_o        (mem_en),
      .mem_addr_o      (mem_addr),
      .mem_rdata_i     (mem_rdata)
   );

   // Behavioural RAM: contents fixed for the run, read data RD_LAT cycles after mem_en.
   logic [2:0] ram [512];
   logic [2:0] rd_pipe [RD_LAT];
   always @(posedge clk) begin
      rd_pipe[0] <= mem_en ? ram[mem_addr] : 3'd0;
      for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
   end
   assign mem_rdata = rd_pipe[RD_LAT-1];

   typedef struct {int due; int data;} rsp_t;
   rsp_t dq[$];
   int   cyc = 0;
   int   n_checks = 0;
   int   n_fail = 0;

   // Model state and expected outputs after the most recent edge
   bit   busy, pend;
   bit   c_oob;
   int   c_addr, c_due;
   int   e_dv, e_dd, e_cv, e_cd, e_rdy, e_en, e_addr;

   function automatic void tile(input int x, input int y, output bit oob, output int a);
      oob = (x / 32 >= 20) || (y / 32 >= 15);
      a   = ((y / 32) * 20 + x / 32) % 512;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s at cycle %0d: observed %0d expected %0d", tag, cyc, obs, exp);
      end
   endtask

   task automatic step(input bit rst, input bit dreq, input int dx, input int dy,
                       input bit cv, input int cx, input int cy);
      bit oob, rsp_now;
      int a, old_rdy;
      reset = rst; disp_req = dreq; col_req_valid = cv;
      disp_x = 10'(dx); disp_y = 10'(dy); col_x = 10'(cx); col_y = 10'(cy);
      @(posedge clk);
      cyc++;
      if (rst) begin
         dq.delete();
         busy = 0; pend = 0;
         e_dv = 0; e_dd = 0; e_cv = 0; e_cd = 0; e_rdy = 1; e_en = 0; e_addr = 0;
      end else begin
         old_rdy = e_rdy;
         rsp_now = 0;
         e_en = 0;
         if (dreq) begin
            tile(dx, dy, oob, a);
            dq.push_back('{due: cyc + RD_LAT + 1, data: oob ? OOB_DISP : int'(ram[a])});
            if (!oob) begin e_en = 1; e_addr = a; end
         end
         if (pend && (c_oob || !dreq)) begin
            pend = 0;
            c_due = cyc + RD_LAT + 1;
            if (!c_oob) begin e_en = 1; e_addr = c_addr; end
         end
         e_dv = 0;
         if (dq.size() > 0 && dq[0].due == cyc) begin
            e_dv = 1; e_dd = dq[0].data; void'(dq.pop_front());
         end
         e_cv = 0;
         if (busy && !pend && c_due == cyc) begin
            e_cv = 1; e_cd = c_oob ? OOB_COL : int'(ram[c_addr]);
            busy = 0; rsp_now = 1;
         end
         if (cv && old_rdy == 1) begin
            busy = 1; pend = 1;
            tile(cx, cy, c_oob, c_addr);
         end
         e_rdy = (!busy && !rsp_now) ? 1 : 0;
      end
      #1;
      chk("disp_valid", 32'(disp_valid), e_dv);
      chk("disp_data", 32'(disp_data), e_dd);
      chk("col_rsp_valid", 32'(col_rsp_valid), e_cv);
      chk("col_rsp_data", 32'(col_rsp_data), e_cd);
      chk("col_req_ready", 32'(col_req_ready), e_rdy);
      chk("mem_en", 32'(mem_en), e_en);
      chk("mem_addr", 32'(mem_addr), e_addr);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      for (int i = 0; i < 512; i++) ram[i] = 3'($urandom);
      for (int i = 0; i < RD_LAT; i++) rd_pipe[i] = 3'd0;
      step(1, 0, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0, 0);
      // Display fetch at origin
      step(0, 1, 0, 0, 0, 0, 0);
      idle(3);
      // Collision query (100,70) -> tile 43
      step(0, 0, 0, 0, 1, 100, 70);
      idle(5);
      // Display collides with pending collision issue
      step(0, 0, 0, 0, 1, 40, 40);
      step(0, 1, 300, 200, 0, 0, 0);
      idle(5);
      // Out-of-range collision and display
      step(0, 0, 0, 0, 1, 700, 10);
      idle(4);
      step(0, 1, 0, 480, 0, 0, 0);
      idle(3);
      // Same-cycle display and new query
      step(0, 1, 608, 448, 1, 639, 479);
      idle(4);
      // Display burst starves a pending query; coords change after handshake
      step(0, 0, 0, 0, 1, 64, 64);
      for (int i = 0; i < 10; i++) step(0, 1, i * 32, 32, 0, 500, 400);
      idle(5);
      // Reset while the query is in flight
      step(0, 0, 0, 0, 1, 100, 100);
      step(0, 0, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0, 0);
      idle(4);
      step(0, 0, 0, 0, 1, 200, 300);
      idle(5);
      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         step(($urandom_range(0, 199) == 0), ($urandom_range(0, 5) == 0),
              int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)),
              ($urandom_range(0, 1) == 1),
              int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)));
      end
      idle(6);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
